i2s_rx_stream_arbiter: RTL and testbench

- Shares the single uDMA RX stream between two I2S RX channel sample streams (ch0, ch1), after the sck-to-system-clock CDC FIFOs.
- Runs on the system clock.
- Grants one sample per cycle through a registered output stage, using one of four modes: ch0 only, ch1 only, round-robin, or strict ch0/ch1 alternation for interleaved stereo.
- Tags each sample with its source and keeps saturating per-source sample counters.

---
 rtl/i2s_rx_stream_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_i2s_rx_stream_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// i2s_rx_stream_arbiter
//
// Shares the single uDMA RX stream between the two I2S RX channel sample
// streams. It sits after the sck-to-system-clock CDC FIFOs, so everything here
// runs on the system clock. At most one input sample is granted per cycle into
// a registered output stage. Each forwarded sample is tagged with its source
// channel and counted in a saturating per-source counter.
//
// Ports:
//   clk_i        system clock, rising edge
//   rstn_i       asynchronous active-low reset
//   cfg_en_i     arbiter enable; low stops new grants, the output still drains
//   cfg_mode_i   00 ch0 only, 01 ch1 only, 10 round-robin, 11 strict alternate
//   cfg_clr_i    single-cycle pulse that clears both sample counters
//   in0_*        ch0 sample stream (valid/ready handshake)
//   in1_*        ch1 sample stream (valid/ready handshake)
//   out_data_o   registered sample to the uDMA
//   out_src_o    source of out_data_o (0 = ch0, 1 = ch1)
//   out_valid_o  output sample valid; held until out_ready_i
//   out_ready_i  uDMA accepts the output sample
//   stat_cnt0_o  saturating count of samples forwarded from ch0
//   stat_cnt1_o  saturating count of samples forwarded from ch1
//   busy_o       equals out_valid_o
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2s_rx_stream_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_en_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic              cfg_clr_i,
    input  logic [DATA_W-1:0] in0_data_i,
    input  logic              in0_valid_i,
    output logic              in0_ready_o,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic              in1_valid_i,
    output logic              in1_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_src_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  stat_cnt0_o,
    output logic [CNT_W-1:0]  stat_cnt1_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        MODE_CH0 = 2'b00,
        MODE_CH1 = 2'b01,
        MODE_RR  = 2'b10,
        MODE_ALT = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mode_e             mode;
    logic              s_slot;
    logic              grant0;
    logic              grant1;
    logic              xfer0;
    logic              xfer1;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_src_q;
    logic              r_last;
    logic              r_expect;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    assign mode = mode_e'(cfg_mode_i);

    // The output register can take a new sample when it is empty or when
    // its current sample leaves this cycle, giving one sample per cycle.
    assign s_slot = ~out_valid_q | out_ready_i;

    // Source selection. Round-robin only consults r_last when both channels
    // compete; strict alternation stalls the non-expected channel even if it
    // is valid so that stereo pairs stay interleaved ch0, ch1, ch0, ...
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (mode)
            MODE_CH0: grant0 = in0_valid_i;
            MODE_CH1: grant1 = in1_valid_i;
            MODE_RR: begin
                if (in0_valid_i && in1_valid_i) begin
                    grant0 = r_last;
                    grant1 = ~r_last;
                end else begin
                    grant0 = in0_valid_i;
                    grant1 = in1_valid_i;
                end
            end
            MODE_ALT: begin
                grant0 = ~r_expect & in0_valid_i;
                grant1 = r_expect & in1_valid_i;
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

    assign in0_ready_o = cfg_en_i & s_slot & grant0;
    assign in1_ready_o = cfg_en_i & s_slot & grant1;

    assign xfer0 = in0_valid_i & in0_ready_o;
    assign xfer1 = in1_valid_i & in1_ready_o;

    // Output register: reload on any input transfer (also when the previous
    // sample leaves in the same edge), otherwise drop valid once accepted.
    // Data and source hold their last value after the sample drains.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else if (xfer0 || xfer1) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xfer1 ? in1_data_i : in0_data_i;
            out_src_q   <= xfer1;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Arbitration pointers. While disabled they are pinned so that every
    // re-enable starts with ch0. Each pointer only moves on transfers made
    // in the mode that owns it; a mode change does not reset them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last   <= 1'b1;
            r_expect <= 1'b0;
        end else if (!cfg_en_i) begin
            r_last   <= 1'b1;
            r_expect <= 1'b0;
        end else begin
            if (mode == MODE_RR && (xfer0 || xfer1)) begin
                r_last <= xfer1;
            end
            if (mode == MODE_ALT && (xfer0 || xfer1)) begin
                r_expect <= ~r_expect;
            end
        end
    end

    // Per-source sample counters. They stick at all-ones instead of
    // wrapping, and a clear pulse wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (cfg_clr_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer0 && cnt0_q != CNT_MAX) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (xfer1 && cnt1_q != CNT_MAX) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign busy_o      = out_valid_q;
    assign stat_cnt0_o = cnt0_q;
    assign stat_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_i2s_rx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_stream_arbiter
//
// Self-checking bench for i2s_rx_stream_arbiter. A default instance and a
// CNT_W=4 instance share all inputs; the small one exposes counter
// saturation. A behavioural model tracks which channel should be served next
// and what the output register must hold, and is compared with the DUT on
// every falling edge. Directed phases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2s_rx_stream_arbiter;

    logic        clk_i;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [1:0]  cfg_mode_i;
    logic        cfg_clr_i;
    logic        in0_valid_i;
    logic        in1_valid_i;
    logic        out_ready_i;
    wire  [31:0] in0_data_i;
    wire  [31:0] in1_data_i;

    wire         in0_ready_o;
    wire         in1_ready_o;
    wire  [31:0] out_data_o;
    wire         out_src_o;
    wire         out_valid_o;
    wire  [15:0] stat_cnt0_o;
    wire  [15:0] stat_cnt1_o;
    wire         busy_o;

    wire         s_in0_ready;
    wire         s_in1_ready;
    wire  [31:0] s_out_data;
    wire         s_out_src;
    wire         s_out_valid;
    wire  [3:0]  s_cnt0;
    wire  [3:0]  s_cnt1;
    wire         s_busy;

    logic [31:0] base0;
    logic [31:0] base1;
    int          n0;
    int          n1;

    int          checks;
    int          failures;

    // model state
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_src;
    int          m_cnt0;
    int          m_cnt1;
    int          m_rr_pref;
    int          m_alt;

    logic [31:0] seen_data[$];
    logic        seen_src[$];

    assign in0_data_i = base0 + 32'(n0);
    assign in1_data_i = base1 + 32'(n1);

    i2s_rx_stream_arbiter dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_clr_i   (cfg_clr_i),
        .in0_data_i  (in0_data_i),
        .in0_valid_i (in0_valid_i),
        .in0_ready_o (in0_ready_o),
        .in1_data_i  (in1_data_i),
        .in1_valid_i (in1_valid_i),
        .in1_ready_o (in1_ready_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .stat_cnt0_o (stat_cnt0_o),
        .stat_cnt1_o (stat_cnt1_o),
        .busy_o      (busy_o)
    );

    i2s_rx_stream_arbiter #(.DATA_W(32), .CNT_W(4)) dut_s (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_clr_i   (cfg_clr_i),
        .in0_data_i  (in0_data_i),
        .in0_valid_i (in0_valid_i),
        .in0_ready_o (s_in0_ready),
        .in1_data_i  (in1_data_i),
        .in1_valid_i (in1_valid_i),
        .in1_ready_o (s_in1_ready),
        .out_data_o  (s_out_data),
        .out_src_o   (s_out_src),
        .out_valid_o (s_out_valid),
        .out_ready_i (out_ready_i),
        .stat_cnt0_o (s_cnt0),
        .stat_cnt1_o (s_cnt1),
        .busy_o      (s_busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Source drivers: each channel presents base+n and advances n once its
    // sample has been accepted, so data stays stable while valid.
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            n0 <= 0;
            n1 <= 0;
        end else begin
            if (in0_valid_i && in0_ready_o) n0 <= n0 + 1;
            if (in1_valid_i && in1_ready_o) n1 <= n1 + 1;
        end
    end

    // Record every sample the uDMA side takes, for the literal sequence checks.
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            seen_data.delete();
            seen_src.delete();
        end else if (out_valid_o && out_ready_i) begin
            seen_data.push_back(out_data_o);
            seen_src.push_back(out_src_o);
        end
    end

    // Which channel the rules say is served right now (readiness).
    function automatic logic m_ready(input int ch);
        logic v_ch;
        v_ch = (ch == 0) ? in0_valid_i : in1_valid_i;
        if (!cfg_en_i) return 1'b0;
        if (m_valid && !out_ready_i) return 1'b0;
        case (cfg_mode_i)
            2'b00: return (ch == 0) && v_ch;
            2'b01: return (ch == 1) && v_ch;
            2'b10: begin
                if (in0_valid_i && in1_valid_i) return ch == m_rr_pref;
                return v_ch;
            end
            default: return (ch == m_alt) && v_ch;
        endcase
    endfunction

    function automatic logic [31:0] sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? 32'(mx) : 32'(c);
    endfunction

    // Behavioural model of the output register, preferences and counts.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_src     <= 1'b0;
            m_cnt0    <= 0;
            m_cnt1    <= 0;
            m_rr_pref <= 0;
            m_alt     <= 0;
        end else begin
            logic g0;
            logic g1;
            g0 = m_ready(0);
            g1 = m_ready(1);
            if (g0 || g1) begin
                m_valid <= 1'b1;
                m_data  <= g0 ? in0_data_i : in1_data_i;
                m_src   <= g1;
            end else if (out_ready_i) begin
                m_valid <= 1'b0;
            end
            if (cfg_clr_i) begin
                m_cnt0 <= 0;
                m_cnt1 <= 0;
            end else begin
                m_cnt0 <= m_cnt0 + (g0 ? 1 : 0);
                m_cnt1 <= m_cnt1 + (g1 ? 1 : 0);
            end
            if (!cfg_en_i) begin
                m_rr_pref <= 0;
                m_alt     <= 0;
            end else begin
                if (cfg_mode_i == 2'b10 && (g0 || g1)) m_rr_pref <= g0 ? 1 : 0;
                if (cfg_mode_i == 2'b11 && (g0 || g1)) m_alt <= 1 - m_alt;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] mode, input logic v0,
                                 input logic v1, input logic rdy, input logic clr);
        cfg_en_i    = en;
        cfg_mode_i  = mode;
        in0_valid_i = v0;
        in1_valid_i = v1;
        out_ready_i = rdy;
        cfg_clr_i   = clr;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic doReset(input logic [1:0] mode);
        rstn_i = 1'b0;
        applyStimulus(1'b0, mode, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCycles(2);
        rstn_i = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        base0    = 32'h0;
        base1    = 32'h0;
        rstn_i   = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        fork
            // continuous comparison against the model
            begin
                forever begin
                    @(negedge clk_i);
                    if (rstn_i) begin
                        checkOutput("in0_ready", 32'(in0_ready_o), 32'(m_ready(0)));
                        checkOutput("in1_ready", 32'(in1_ready_o), 32'(m_ready(1)));
                        checkOutput("out_valid", 32'(out_valid_o), 32'(m_valid));
                        checkOutput("out_data", out_data_o, m_data);
                        checkOutput("out_src", 32'(out_src_o), 32'(m_src));
                        checkOutput("busy", 32'(busy_o), 32'(m_valid));
                        checkOutput("cnt0", 32'(stat_cnt0_o), sat(m_cnt0, 16));
                        checkOutput("cnt1", 32'(stat_cnt1_o), sat(m_cnt1, 16));
                        checkOutput("cnt0_w4", 32'(s_cnt0), sat(m_cnt0, 4));
                        checkOutput("cnt1_w4", 32'(s_cnt1), sat(m_cnt1, 4));
                    end
                end
            end
            // directed phases
            begin
                // reset state
                #3;
                checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
                checkOutput("rst_data", out_data_o, 32'd0);
                checkOutput("rst_cnt0", 32'(stat_cnt0_o), 32'd0);

                // Round-robin, both always valid
                doReset(2'b10);
                base0 = 32'hA0;
                base1 = 32'hB0;
                applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(1);
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk_i);
                checkOutput("rr_valid_before", 32'(out_valid_o), 32'd0);
                checkOutput("rr_first_rdy0", 32'(in0_ready_o), 32'd1);
                checkOutput("rr_first_rdy1", 32'(in1_ready_o), 32'd0);
                stepCycles(1);
                @(negedge clk_i);
                checkOutput("rr_valid_after", 32'(out_valid_o), 32'd1);
                checkOutput("rr_first_data", out_data_o, 32'hA0);
                stepCycles(6);
                applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(2);
                checkOutput("rr_count", 32'(seen_data.size() >= 6), 32'd1);
                for (int i = 0; i < 6; i++) begin
                    checkOutput("rr_seq_data", (i < seen_data.size()) ? seen_data[i] : 32'hDEAD_BEEF,
                                ((i % 2) ? 32'hB0 : 32'hA0) + 32'(i / 2));
                    checkOutput("rr_seq_src", (i < seen_src.size()) ? 32'(seen_src[i]) : 32'hDEAD_BEEF,
                                32'(i % 2));
                end

                // Strict alternation, ch1 waits for ch0
                doReset(2'b11);
                base0 = 32'hD0;
                base1 = 32'hC0;
                applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    checkOutput("alt_rdy1_stall", 32'(in1_ready_o), 32'd0);
                    checkOutput("alt_no_out", 32'(out_valid_o), 32'd0);
                    stepCycles(1);
                end
                applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk_i);
                checkOutput("alt_rdy0", 32'(in0_ready_o), 32'd1);
                checkOutput("alt_rdy1", 32'(in1_ready_o), 32'd0);
                stepCycles(3);
                applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                stepCycles(2);
                checkOutput("alt_first_data", (seen_data.size() > 0) ? seen_data[0] : 32'hDEAD_BEEF, 32'hD0);
                checkOutput("alt_first_src", (seen_src.size() > 0) ? 32'(seen_src[0]) : 32'hDEAD_BEEF, 32'd0);
                checkOutput("alt_second_data", (seen_data.size() > 1) ? seen_data[1] : 32'hDEAD_BEEF, 32'hC0);
                checkOutput("alt_second_src", (seen_src.size() > 1) ? 32'(seen_src[1]) : 32'hDEAD_BEEF, 32'd1);

                // Round-robin with output back-pressure
                doReset(2'b10);
                base0 = 32'hE0;
                base1 = 32'hF0;
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(3);
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk_i);
                    checkOutput("bp_rdy0", 32'(in0_ready_o), 32'd0);
                    checkOutput("bp_rdy1", 32'(in1_ready_o), 32'd0);
                    checkOutput("bp_hold_valid", 32'(out_valid_o), 32'd1);
                    checkOutput("bp_hold_data", out_data_o, 32'hE1);
                    stepCycles(1);
                end
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(4);
                applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(2);
                checkOutput("bp_count", 32'(seen_data.size()), 32'd7);
                for (int i = 0; i < 7; i++) begin
                    checkOutput("bp_seq_data", (i < seen_data.size()) ? seen_data[i] : 32'hDEAD_BEEF,
                                ((i % 2) ? 32'hF0 : 32'hE0) + 32'(i / 2));
                end

                // ch0 only, counters, saturation and clear
                doReset(2'b00);
                base0 = 32'h100;
                base1 = 32'h200;
                applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_i);
                    checkOutput("m0_rdy1", 32'(in1_ready_o), 32'd0);
                    stepCycles(1);
                end
                applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk_i);
                checkOutput("m0_cnt0_10", 32'(stat_cnt0_o), 32'd10);
                checkOutput("m0_cnt1_0", 32'(stat_cnt1_o), 32'd0);
                checkOutput("m0_cnt0_w4_10", 32'(s_cnt0), 32'd10);
                stepCycles(1);
                applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_i);
                    checkOutput("m0_rdy1", 32'(in1_ready_o), 32'd0);
                    stepCycles(1);
                end
                applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk_i);
                checkOutput("m0_cnt0_20", 32'(stat_cnt0_o), 32'd20);
                checkOutput("m0_cnt0_w4_sat", 32'(s_cnt0), 32'd15);
                checkOutput("m0_cnt1_still0", 32'(stat_cnt1_o), 32'd0);
                stepCycles(2);
                applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
                stepCycles(1);
                applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                @(negedge clk_i);
                checkOutput("clr_cnt0", 32'(stat_cnt0_o), 32'd0);
                checkOutput("clr_cnt0_w4", 32'(s_cnt0), 32'd0);
                checkOutput("clr_xfer_valid", 32'(out_valid_o), 32'd1);
                checkOutput("clr_xfer_data", out_data_o, 32'h114);
                stepCycles(2);

                // Reset while a sample is held, then re-enable
                doReset(2'b10);
                base0 = 32'h300;
                base1 = 32'h400;
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
                stepCycles(2);
                @(negedge clk_i);
                checkOutput("ar_held_valid", 32'(out_valid_o), 32'd1);
                #2;
                rstn_i = 1'b0;
                #1;
                checkOutput("ar_valid_dropped", 32'(out_valid_o), 32'd0);
                checkOutput("ar_data_cleared", out_data_o, 32'd0);
                checkOutput("ar_busy", 32'(busy_o), 32'd0);
                applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(1);
                rstn_i = 1'b1;
                stepCycles(1);
                applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
                stepCycles(1);
                @(negedge clk_i);
                checkOutput("ar_first_src", 32'(out_src_o), 32'd0);
                checkOutput("ar_first_data", out_data_o, 32'h300);
                stepCycles(2);
                applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
                stepCycles(2);
            end
        join_any

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
